// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response channel between one requester and the ALU arbiter
interface alu_share_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int OP_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_first;
   logic [DATA_W-1:0] req_second;
   logic [OP_W-1:0]   req_op;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;
   logic              rsp_err;
   modport master (
      output req_valid, req_first, req_second, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
   );
   modport slave (
      input  req_valid, req_first, req_second, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters, returning each result only to its issuer
module alu_share_arbiter #(
   parameter int DATA_W = 16,
   parameter int OP_W = 4,
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   alu_share_arbiter_if.slave req0,
   alu_share_arbiter_if.slave req1,
   output logic [DATA_W-1:0]  alu_first_o,
   output logic [DATA_W-1:0]  alu_second_o,
   output logic [OP_W-1:0]    alu_op_o,
   input  logic [DATA_W-1:0]  alu_result_i,
   input  logic               alu_zero_i
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   localparam logic [OP_W-1:0] OP_ZERO = OP_W'(8);
   localparam logic [OP_W-1:0] OP_MAX = OP_W'(12);
   state_t            state_q;
   logic              owner_q;
   logic              last_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [OP_W-1:0]   op_q;
   logic [1:0]        rsp_valid_q;
   logic [1:0]        rsp_zero_q;
   logic [1:0]        rsp_err_q;
   logic [DATA_W-1:0] rsp_result_q [2];
   logic              gnt1;
   logic              accept;
   logic              illegal;
   logic              rsp_take;
   always_comb begin
      gnt1 = req1.req_valid && (!req0.req_valid || (!PRIO_FIXED && !last_q));
      accept = (state_q == IDLE) && (req0.req_valid || req1.req_valid);
      illegal = op_q > OP_MAX;
      rsp_take = owner_q ? req1.rsp_ready : req0.rsp_ready;
   end
   assign req0.req_ready = (state_q == IDLE) && req0.req_valid && !gnt1;
   assign req1.req_ready = (state_q == IDLE) && gnt1;
   assign alu_first_o = a_q;
   assign alu_second_o = b_q;
   assign alu_op_o = op_q;
   assign req0.rsp_valid = rsp_valid_q[0];
   assign req0.rsp_result = rsp_result_q[0];
   assign req0.rsp_zero = rsp_zero_q[0];
   assign req0.rsp_err = rsp_err_q[0];
   assign req1.rsp_valid = rsp_valid_q[1];
   assign req1.rsp_result = rsp_result_q[1];
   assign req1.rsp_zero = rsp_zero_q[1];
   assign req1.rsp_err = rsp_err_q[1];
   // Illegal op codes bypass the ALU result and report a forced zero with err set
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q <= 1'b1;
         a_q <= '0;
         b_q <= '0;
         op_q <= OP_ZERO;
         rsp_valid_q <= '0;
         rsp_zero_q <= '0;
         rsp_err_q <= '0;
         rsp_result_q <= '{default: '0};
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               a_q <= gnt1 ? req1.req_first : req0.req_first;
               b_q <= gnt1 ? req1.req_second : req0.req_second;
               op_q <= gnt1 ? req1.req_op : req0.req_op;
               owner_q <= gnt1;
               last_q <= gnt1;
               state_q <= EXEC;
            end
            EXEC: begin
               rsp_result_q[owner_q] <= illegal ? '0 : alu_result_i;
               rsp_zero_q[owner_q] <= illegal || alu_zero_i;
               rsp_err_q[owner_q] <= illegal;
               rsp_valid_q[owner_q] <= 1'b1;
               state_q <= RESP;
            end
            RESP: if (rsp_take) begin
               rsp_valid_q[owner_q] <= 1'b0;
               op_q <= OP_ZERO;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random checks of the ALU share arbiter against a transaction model
module tb_alu_share_arbiter;
   localparam bit PRIO = 1'b0;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int passed = 0;
   logic        v [2];
   logic        rr [2];
   logic [15:0] a [2];
   logic [15:0] b [2];
   logic [3:0]  op [2];
   alu_share_arbiter_if i0 ();
   alu_share_arbiter_if i1 ();
   alu_share_arbiter_if f0 ();
   alu_share_arbiter_if f1 ();
   logic [15:0] alu_a, alu_b, alu_r, fix_a, fix_b, fix_r;
   logic [3:0]  alu_o, fix_o;
   function automatic logic [15:0] alu_f(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      case (o)
         4'd0: return x + y;
         4'd1: return x - y;
         4'd2: return x & y;
         4'd3: return x | y;
         4'd4: return x ^ y;
         4'd5: return ~x;
         4'd6: return x << 1;
         4'd7: return x >> 1;
         4'd8: return 16'h0;
         4'd9: return y;
         4'd10: return x;
         4'd11: return x + 16'd1;
         4'd12: return x - 16'd1;
         default: return x | y | 16'h1;
      endcase
   endfunction
   assign i0.req_valid = v[0];
   assign i0.req_first = a[0];
   assign i0.req_second = b[0];
   assign i0.req_op = op[0];
   assign i0.rsp_ready = rr[0];
   assign i1.req_valid = v[1];
   assign i1.req_first = a[1];
   assign i1.req_second = b[1];
   assign i1.req_op = op[1];
   assign i1.rsp_ready = rr[1];
   assign alu_r = alu_f(alu_o, alu_a, alu_b);
   alu_share_arbiter #(.DATA_W(16), .OP_W(4), .PRIO_FIXED(PRIO)) dut (
      .clk(clk), .rst(rst), .req0(i0), .req1(i1),
      .alu_first_o(alu_a), .alu_second_o(alu_b), .alu_op_o(alu_o),
      .alu_result_i(alu_r), .alu_zero_i(alu_r == 16'h0)
   );
   assign f0.req_valid = 1'b1;
   assign f0.req_first = 16'h0011;
   assign f0.req_second = 16'h0022;
   assign f0.req_op = 4'd0;
   assign f0.rsp_ready = 1'b1;
   assign f1.req_valid = 1'b1;
   assign f1.req_first = 16'h0033;
   assign f1.req_second = 16'h0044;
   assign f1.req_op = 4'd1;
   assign f1.rsp_ready = 1'b1;
   assign fix_r = alu_f(fix_o, fix_a, fix_b);
   alu_share_arbiter #(.DATA_W(16), .OP_W(4), .PRIO_FIXED(1'b1)) dut_fix (
      .clk(clk), .rst(rst), .req0(f0), .req1(f1),
      .alu_first_o(fix_a), .alu_second_o(fix_b), .alu_op_o(fix_o),
      .alu_result_i(fix_r), .alu_zero_i(fix_r == 16'h0)
   );
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
   endtask
   // Transaction model: one op in flight; age 0 = operands on the ALU, age 1 = response offered
   bit          mdl_ok = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_own = 1'b0;
   bit          m_last = 1'b1;
   int          m_age = 0;
   logic [15:0] m_a, m_b, p_res;
   logic [3:0]  m_op;
   logic        p_zero, p_err, e0, e1;
   logic [15:0] m_res [2];
   logic        m_zero [2];
   logic        m_err [2];
   always @(negedge clk) begin
      e1 = !m_busy && i1.req_valid && (!i0.req_valid || (!PRIO && !m_last));
      e0 = !m_busy && i0.req_valid && !e1;
      if (mdl_ok) begin
         chk("req0_ready", i0.req_ready, e0);
         chk("req1_ready", i1.req_ready, e1);
         chk("rsp0_valid", i0.rsp_valid, m_busy && m_age == 1 && !m_own);
         chk("rsp1_valid", i1.rsp_valid, m_busy && m_age == 1 && m_own);
         chk("rsp0_result", i0.rsp_result, m_res[0]);
         chk("rsp0_zero", i0.rsp_zero, m_zero[0]);
         chk("rsp0_err", i0.rsp_err, m_err[0]);
         chk("rsp1_result", i1.rsp_result, m_res[1]);
         chk("rsp1_zero", i1.rsp_zero, m_zero[1]);
         chk("rsp1_err", i1.rsp_err, m_err[1]);
         chk("alu_op", alu_o, m_op);
         chk("alu_first", alu_a, m_a);
         chk("alu_second", alu_b, m_b);
      end
      if (!rst) begin
         mdl_ok = 1'b1;
         m_busy = 1'b0;
         m_last = 1'b1;
         m_a = '0;
         m_b = '0;
         m_op = 4'd8;
         for (int i = 0; i < 2; i++) begin
            m_res[i] = '0;
            m_zero[i] = 1'b0;
            m_err[i] = 1'b0;
         end
      end else if (mdl_ok) begin
         if (!m_busy && (e0 || e1)) begin
            m_own = e1;
            m_last = e1;
            m_busy = 1'b1;
            m_age = 0;
            m_a = e1 ? i1.req_first : i0.req_first;
            m_b = e1 ? i1.req_second : i0.req_second;
            m_op = e1 ? i1.req_op : i0.req_op;
            p_err = m_op > 4'd12;
            p_res = p_err ? 16'h0 : alu_f(m_op, m_a, m_b);
            p_zero = p_err || p_res == 16'h0;
         end else if (m_busy && m_age == 0) begin
            m_age = 1;
            m_res[m_own] = p_res;
            m_zero[m_own] = p_zero;
            m_err[m_own] = p_err;
         end else if (m_busy && (m_own ? i1.rsp_ready : i0.rsp_ready)) begin
            m_busy = 1'b0;
            m_op = 4'd8;
         end
      end
   end
   int gq [$];
   always @(negedge clk) begin
      if (rst && i0.req_valid && i0.req_ready) gq.push_back(0);
      if (rst && i1.req_valid && i1.req_ready) gq.push_back(1);
   end
   int fix_cnt = 0;
   always @(negedge clk) begin
      if (mdl_ok) chk("fix_req1_ready", f1.req_ready, 1'b0);
      if (rst && f0.req_ready) fix_cnt++;
   end
   task automatic req_op(input int n, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      int t = 0;
      v[n] = 1'b1;
      op[n] = o;
      a[n] = x;
      b[n] = y;
      do begin
         @(negedge clk);
         t++;
      end while (!(n == 1 ? i1.req_ready : i0.req_ready) && t < 100);
      if (t >= 100) chk("req_timeout", n == 1 ? i1.req_ready : i0.req_ready, 1'b1);
      @(posedge clk);
      #1 v[n] = 1'b0;
   endtask
   task automatic wait_rsp(input int n, output int t);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(n == 1 ? i1.rsp_valid : i0.rsp_valid) && t < 100);
      if (t >= 100) chk("rsp_timeout", n == 1 ? i1.rsp_valid : i0.rsp_valid, 1'b1);
   endtask
   task automatic rand_req(input int n);
      int k;
      logic [15:0] x, y;
      k = $urandom_range(0, 3);
      repeat (k) @(posedge clk);
      if (k > 0) #1;
      x = 16'($urandom);
      y = ($urandom_range(0, 3) == 0) ? x : 16'($urandom);
      req_op(n, 4'($urandom_range(0, 15)), x, y);
   endtask
   bit d0 = 1'b0;
   bit d1 = 1'b0;
   initial begin
      int t, g_base;
      int exp_g [4] = '{0, 1, 0, 1};
      for (int i = 0; i < 2; i++) begin
         v[i] = 1'b0;
         rr[i] = 1'b1;
         a[i] = '0;
         b[i] = '0;
         op[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("reset_alu_op", alu_o, 4'd8);
      chk("reset_rsp0_valid", i0.rsp_valid, 1'b0);
      @(posedge clk);
      #1;
      req_op(0, 4'd0, 16'h0003, 16'h0004);
      wait_rsp(0, t);
      chk("add_latency", t, 2);
      chk("add_result", i0.rsp_result, 16'h0007);
      chk("add_zero", i0.rsp_zero, 1'b0);
      @(posedge clk);
      #1;
      req_op(1, 4'd1, 16'h1234, 16'h1234);
      wait_rsp(1, t);
      chk("sub_result", i1.rsp_result, 16'h0000);
      chk("sub_zero", i1.rsp_zero, 1'b1);
      chk("sub_rsp0_idle", i0.rsp_valid, 1'b0);
      @(posedge clk);
      #1;
      req_op(0, 4'hE, 16'h5555, 16'h0101);
      wait_rsp(0, t);
      chk("illegal_err", i0.rsp_err, 1'b1);
      chk("illegal_result", i0.rsp_result, 16'h0000);
      chk("illegal_zero", i0.rsp_zero, 1'b1);
      @(posedge clk);
      #1;
      req_op(0, 4'd0, 16'h0001, 16'h0001);
      wait_rsp(0, t);
      chk("legal_err_clear", i0.rsp_err, 1'b0);
      chk("legal_result", i0.rsp_result, 16'h0002);
      @(posedge clk);
      #1 rr[0] = 1'b0;
      req_op(0, 4'd2, 16'hF0F0, 16'h0FF0);
      fork
         req_op(1, 4'd3, 16'h0A00, 16'h000B);
      join_none
      wait_rsp(0, t);
      repeat (5) begin
         chk("hold_valid", i0.rsp_valid, 1'b1);
         chk("hold_result", i0.rsp_result, 16'h00F0);
         chk("hold_no_accept", i1.req_ready, 1'b0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 rr[0] = 1'b1;
      @(negedge clk);
      chk("handshake_no_accept", i1.req_ready, 1'b0);
      @(posedge clk);
      #1 rr[0] = 1'b0;
      @(negedge clk);
      chk("accept_resumes", i1.req_ready, 1'b1);
      wait_rsp(1, t);
      chk("or_result", i1.rsp_result, 16'h0A0B);
      @(posedge clk);
      #1 rr[0] = 1'b1;
      req_op(0, 4'd0, 16'h0005, 16'h0006);
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_rsp0_valid", i0.rsp_valid, 1'b0);
      chk("midrst_alu_op", alu_o, 4'd8);
      @(posedge clk);
      #1;
      req_op(0, 4'd0, 16'h0005, 16'h0006);
      wait_rsp(0, t);
      chk("after_rst_result", i0.rsp_result, 16'h000B);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      g_base = gq.size();
      fork
         begin
            req_op(0, 4'd4, 16'h00FF, 16'h0F0F);
            req_op(0, 4'd9, 16'h1111, 16'h2222);
         end
         begin
            req_op(1, 4'd11, 16'h7FFF, 16'h0000);
            req_op(1, 4'd7, 16'h8000, 16'h0000);
         end
      join
      wait_rsp(1, t);
      chk("rr_grant_count", gq.size() - g_base, 4);
      if (gq.size() >= g_base + 4)
         for (int i = 0; i < 4; i++) chk("rr_grant_order", gq[g_base + i], exp_g[i]);
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 150; i++) rand_req(0);
            d0 = 1'b1;
         end
         begin
            for (int i = 0; i < 150; i++) rand_req(1);
            d1 = 1'b1;
         end
         while (!(d0 && d1)) begin
            @(posedge clk);
            #1;
            rr[0] = $urandom_range(0, 3) != 0;
            rr[1] = $urandom_range(0, 3) != 0;
         end
      join
      rr[0] = 1'b1;
      rr[1] = 1'b1;
      repeat (6) @(posedge clk);
      chk("fix_req0_grants", fix_cnt >= 50, 1'b1);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
